// File: rtl/lcd_hd44780_driver.sv
// ============================================================================
// Module   : lcd_hd44780_driver
// Purpose  : Turns the memory-mapped LCD register written by software into
//            timed HD44780 write cycles (setup, EN pulse, hold, execution
//            wait). A request is a flip of bit 30. Each request is held in a
//            one-deep buffer until the bus is free.
// Ports    : i_clk       - system clock
//            i_reset     - asynchronous active-low reset
//            i_io_lcd    - [31] power, [30] request toggle, [8] RS, [7:0] byte
//            o_lcd_on    - LCD power/backlight enable (i_io_lcd[31] delayed 1)
//            o_lcd_rs    - register select
//            o_lcd_rw    - read/write, always 0 (write-only bus)
//            o_lcd_en    - enable strobe
//            o_lcd_data  - DB[7:0]
//            o_busy      - FSM not idle or a request is pending
//            o_overrun   - sticky: a pending request was overwritten
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_hd44780_driver #(
  parameter int SETUP_CYC     = 2,
  parameter int EN_HIGH_CYC   = 13,
  parameter int HOLD_CYC      = 2,
  parameter int EXEC_CYC      = 2000,
  parameter int LONG_EXEC_CYC = 82000,
  parameter int POWERUP_CYC   = 750000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_io_lcd,
  output logic        o_lcd_on,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic [7:0]  o_lcd_data,
  output logic        o_busy,
  output logic        o_overrun
);

  localparam int MAX_A = (SETUP_CYC > EN_HIGH_CYC) ? SETUP_CYC : EN_HIGH_CYC;
  localparam int MAX_B = (HOLD_CYC > EXEC_CYC) ? HOLD_CYC : EXEC_CYC;
  localparam int MAX_C = (LONG_EXEC_CYC > POWERUP_CYC) ? LONG_EXEC_CYC : POWERUP_CYC;
  localparam int MAX_AB = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_ALL = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
  localparam int CNT_W = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

  // Counter reload values: each phase lasts (value + 1) cycles.
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(EN_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(LONG_EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LD_PWR   = CNT_W'(POWERUP_CYC - 1);

  typedef enum logic [2:0] {
    S_POWERUP = 3'd0,
    S_IDLE    = 3'd1,
    S_SETUP   = 3'd2,
    S_PULSE   = 3'd3,
    S_HOLD    = 3'd4,
    S_EXEC    = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             tog_q;
  logic             pend;
  logic             buf_rs;
  logic [7:0]       buf_data;
  logic             long_q;

  logic toggle;
  logic consume;
  logic cnt_zero;
  logic unused_bits;

  assign toggle      = i_io_lcd[30] ^ tog_q;
  assign consume     = (state == S_IDLE) && pend;
  assign cnt_zero    = (cnt == '0);
  assign o_busy      = (state != S_IDLE) || pend;
  assign o_lcd_rw    = 1'b0;
  assign unused_bits = ^i_io_lcd[29:9];

  // Next-state logic. One shared down-counter times every phase.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_POWERUP: begin
        if (cnt_zero) state_nxt = S_IDLE;
        else          cnt_nxt   = cnt - 1'b1;
      end
      S_IDLE: begin
        if (pend) begin
          state_nxt = S_SETUP;
          cnt_nxt   = LD_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_zero) begin
          state_nxt = S_PULSE;
          cnt_nxt   = LD_EN;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_PULSE: begin
        if (cnt_zero) begin
          state_nxt = S_HOLD;
          cnt_nxt   = LD_HOLD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_zero) begin
          state_nxt = S_EXEC;
          // long_q was latched at the IDLE edge and is stable here.
          cnt_nxt   = long_q ? LD_LONG : LD_EXEC;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_EXEC: begin
        if (cnt_zero) state_nxt = S_IDLE;
        else          cnt_nxt   = cnt - 1'b1;
      end
      default: begin
        state_nxt = S_POWERUP;
        cnt_nxt   = LD_PWR;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= S_POWERUP;
      cnt        <= LD_PWR;
      tog_q      <= 1'b0;
      pend       <= 1'b0;
      buf_rs     <= 1'b0;
      buf_data   <= 8'h00;
      long_q     <= 1'b0;
      o_lcd_on   <= 1'b0;
      o_lcd_rs   <= 1'b0;
      o_lcd_en   <= 1'b0;
      o_lcd_data <= 8'h00;
      o_overrun  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      tog_q    <= i_io_lcd[30];
      o_lcd_on <= i_io_lcd[31];
      // EN is registered from the next state so it is glitch-free and
      // aligned with the PULSE phase.
      o_lcd_en <= (state_nxt == S_PULSE);

      // A new toggle wins over a consume on the same edge: the fresh
      // request refills the buffer and pend stays set.
      if (toggle) begin
        buf_rs   <= i_io_lcd[8];
        buf_data <= i_io_lcd[7:0];
        pend     <= 1'b1;
        if (pend && !consume) o_overrun <= 1'b1;
      end else if (consume) begin
        pend <= 1'b0;
      end

      if (consume) begin
        o_lcd_rs   <= buf_rs;
        o_lcd_data <= buf_data;
        // Clear (0x01) and home (0x02/0x03) need the long execution wait.
        long_q     <= !buf_rs && (buf_data[7:2] == 6'd0) && (buf_data != 8'h00);
      end
    end
  end

endmodule

`default_nettype wire
